// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched_if
// Description : Requester/transmitter signal bundle for uart_tx_sched.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_sched_if #(
  parameter int N = 4
) ();
  logic [N-1:0]   req;
  logic [8*N-1:0] data;
  logic [N-1:0]   last;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           busy;
  logic           tx_send;
  logic [7:0]     tx_data;

  modport master (
    output req, data, last,
    input  ack, grant, busy, tx_send, tx_data
  );

  modport slave (
    input  req, data, last,
    output ack, grant, busy, tx_send, tx_data
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched
// Description : Packet-level round-robin sharing of one UART sender; paces
//               frames itself and generates the send edge.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
  parameter int N            = 4,
  parameter int SEND_HIGH    = 4,
  parameter int FRAME_CYCLES = 256,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  wire logic        sys_clk,
  input  wire logic        sys_rst,
  uart_tx_sched_if.slave   bus
);

  localparam int c_IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int c_FRM_W = $clog2(FRAME_CYCLES);
  localparam int c_HLD_W = $clog2(HOLD_TIMEOUT + 1);

  localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(N - 1);
  localparam logic [c_FRM_W-1:0] c_SEND_END  = c_FRM_W'(SEND_HIGH - 1);
  localparam logic [c_FRM_W-1:0] c_FRAME_END = c_FRM_W'(FRAME_CYCLES - 1);
  localparam logic [c_HLD_W-1:0] c_HOLD_END  = c_HLD_W'(HOLD_TIMEOUT - 1);
  localparam logic [N-1:0]       c_ONE       = N'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t             r_state,     w_state;
  logic [c_IDX_W-1:0] r_owner,     w_owner;
  logic [c_IDX_W-1:0] r_ptr,       w_ptr;
  logic               r_last_seen, w_last_seen;
  logic [c_FRM_W-1:0] r_frm_cnt,   w_frm_cnt;
  logic [c_HLD_W-1:0] r_hld_cnt,   w_hld_cnt;
  logic [N-1:0]       r_grant,     w_grant;
  logic [N-1:0]       r_ack,       w_ack;
  logic               r_tx_send,   w_tx_send;
  logic [7:0]         r_tx_data,   w_tx_data;

  logic               w_any;
  logic [c_IDX_W-1:0] w_win;
  logic [c_IDX_W-1:0] w_load_idx;
  logic               w_load;
  logic               w_release;

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin : b_arb
    int v_idx;
    w_any = 1'b0;
    w_win = '0;
    v_idx = 0;
    for (int k = 0; k < N; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= N) begin
        v_idx = v_idx - N;
      end
      if (!w_any && bus.req[v_idx]) begin
        w_any = 1'b1;
        w_win = c_IDX_W'(v_idx);
      end
    end
  end

  always_comb begin
    w_state     = r_state;
    w_owner     = r_owner;
    w_ptr       = r_ptr;
    w_last_seen = r_last_seen;
    w_frm_cnt   = r_frm_cnt;
    w_hld_cnt   = r_hld_cnt;
    w_grant     = r_grant;
    w_ack       = '0;
    w_tx_send   = r_tx_send;
    w_tx_data   = r_tx_data;
    w_load      = 1'b0;
    w_release   = 1'b0;
    w_load_idx  = r_owner;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_load     = 1'b1;
          w_load_idx = w_win;
        end
      end
      S_SEND: begin
        w_frm_cnt = r_frm_cnt + 1'b1;
        if (r_frm_cnt == c_SEND_END) begin
          w_tx_send = 1'b0;
          w_state   = S_GAP;
        end
      end
      S_GAP: begin
        w_frm_cnt = r_frm_cnt + 1'b1;
        if (r_frm_cnt == c_FRAME_END) begin
          if (r_last_seen) begin
            w_release = 1'b1;
          end else begin
            w_hld_cnt = '0;
            w_state   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // Expiry is checked first so a request arriving on that cycle loses.
        if (r_hld_cnt == c_HOLD_END) begin
          w_release = 1'b1;
        end else if (bus.req[r_owner]) begin
          w_load = 1'b1;
        end else begin
          w_hld_cnt = r_hld_cnt + 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    if (w_load) begin
      w_owner     = w_load_idx;
      w_grant     = c_ONE << w_load_idx;
      w_ack       = c_ONE << w_load_idx;
      w_tx_data   = bus.data[{w_load_idx, 3'b000} +: 8];
      w_last_seen = bus.last[w_load_idx];
      w_tx_send   = 1'b1;
      w_frm_cnt   = '0;
      w_state     = S_SEND;
    end

    if (w_release) begin
      w_grant = '0;
      w_ptr   = (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;
      w_state = S_IDLE;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_last_seen <= 1'b0;
      r_frm_cnt   <= '0;
      r_hld_cnt   <= '0;
      r_grant     <= '0;
      r_ack       <= '0;
      r_tx_send   <= 1'b0;
      r_tx_data   <= 8'h00;
    end else begin
      r_state     <= w_state;
      r_owner     <= w_owner;
      r_ptr       <= w_ptr;
      r_last_seen <= w_last_seen;
      r_frm_cnt   <= w_frm_cnt;
      r_hld_cnt   <= w_hld_cnt;
      r_grant     <= w_grant;
      r_ack       <= w_ack;
      r_tx_send   <= w_tx_send;
      r_tx_data   <= w_tx_data;
    end
  end

  assign bus.ack     = r_ack;
  assign bus.grant   = r_grant;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.tx_send = r_tx_send;
  assign bus.tx_data = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_sched
// Description : Self-checking bench for uart_tx_sched against a time-window
//               model of the scheduling rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

  localparam int N            = 4;
  localparam int SEND_HIGH    = 4;
  localparam int FRAME_CYCLES = 256;
  localparam int HOLD_TIMEOUT = 1024;
  localparam int c_LOW_MIN    = 252;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  uart_tx_sched_if #(.N(N)) u_if ();

  uart_tx_sched #(
    .N            (N),
    .SEND_HIGH    (SEND_HIGH),
    .FRAME_CYCLES (FRAME_CYCLES),
    .HOLD_TIMEOUT (HOLD_TIMEOUT)
  ) u_dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (u_if)
  );

  always #10 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Observed loads: cycle, acked requester, byte on tx_data.
  typedef struct {
    int         cyc;
    int         idx;
    logic [7:0] b;
  } load_t;
  load_t log_q[$];

  // ---------------- reference model and per-cycle checks ----------------
  int         cyc = 0;
  bit         m_hold;
  int         m_from, m_ptr, m_t, m_o;
  bit         m_last;
  logic [N-1:0] m_gnt, exp_ack;
  logic [7:0] m_txd;
  int         hi_cnt, lo_cnt;
  bit         lo_valid, prev_send;

  task automatic model_reset();
    m_hold = 0; m_from = 0; m_ptr = 0; m_t = -100000; m_o = 0; m_last = 1;
    m_gnt = '0; m_txd = 8'h00; hi_cnt = 0; lo_cnt = 0; lo_valid = 0; prev_send = 0;
  endtask

  initial begin
    int  o;
    bit  ld;
    model_reset();
    forever begin
      @(posedge sys_clk);
      cyc++;
      if (sys_rst) begin
        model_reset();
        #1;
        chk("rst_ack", u_if.ack, 0);
        chk("rst_grant", u_if.grant, 0);
        chk("rst_send", u_if.tx_send, 0);
        chk("rst_busy", u_if.busy, 0);
        chk("rst_data", u_if.tx_data, 0);
      end else begin
        ld = 0; o = 0; exp_ack = '0;
        if (m_last && m_gnt != 0 && cyc == m_t + FRAME_CYCLES) m_gnt = '0;
        if (!m_hold) begin
          if (cyc >= m_from && u_if.req != 0) begin
            ld = 1; o = rr_pick(u_if.req, m_ptr);
          end
        end else if (cyc >= m_t + FRAME_CYCLES + 1 && cyc <= m_t + FRAME_CYCLES + HOLD_TIMEOUT - 1
                     && u_if.req[m_o]) begin
          ld = 1; o = m_o;
        end else if (cyc == m_t + FRAME_CYCLES + HOLD_TIMEOUT) begin
          m_gnt = '0; m_hold = 0; m_from = cyc + 1; m_ptr = (m_o + 1) % N;
        end
        if (ld) begin
          m_t = cyc; m_o = o; m_last = u_if.last[o];
          m_txd = u_if.data[8*o +: 8];
          m_gnt = '0; m_gnt[o] = 1'b1; exp_ack = m_gnt;
          if (m_last) begin
            m_hold = 0; m_from = cyc + FRAME_CYCLES + 1; m_ptr = (o + 1) % N;
          end else begin
            m_hold = 1;
          end
        end
        #1;
        chk("ack", u_if.ack, exp_ack);
        chk("grant", u_if.grant, m_gnt);
        chk("busy", u_if.busy, (m_gnt != 0));
        chk("tx_data", u_if.tx_data, m_txd);
        chk("tx_send", u_if.tx_send, (cyc >= m_t && cyc < m_t + SEND_HIGH));
        if (u_if.ack != 0) begin
          for (int i = 0; i < N; i++)
            if (u_if.ack[i]) log_q.push_back('{cyc: cyc, idx: i, b: u_if.tx_data});
        end
        if (u_if.tx_send) begin
          if (!prev_send && lo_valid) chk("send_low_gap", 32'(lo_cnt >= c_LOW_MIN), 1);
          hi_cnt++;
        end else if (prev_send) begin
          chk("send_high_len", hi_cnt, SEND_HIGH);
          hi_cnt = 0; lo_cnt = 1; lo_valid = 1;
        end else begin
          lo_cnt++;
        end
        prev_send = u_if.tx_send;
      end
    end
  end

  // ---------------- requester agents ----------------
  logic [7:0] pb [N][4];
  int  plen [N], pidx [N], stall [N], pstall [N];
  bit  rand_en = 0;
  int  rand_pct = 0, rand_max_len = 1, rand_stall_pct = 0;

  task automatic present(input int i);
    u_if.data[8*i +: 8] = pb[i][pidx[i]];
    u_if.last[i] = (pidx[i] == plen[i] - 1);
  endtask

  task automatic new_pkt(input int i, input int len, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int st);
    pb[i][0] = b0; pb[i][1] = b1; pb[i][2] = b2; pb[i][3] = 8'h00;
    plen[i] = len; pidx[i] = 0; pstall[i] = st; stall[i] = 0;
    present(i);
    u_if.req[i] = 1'b1;
  endtask

  task automatic agent_step();
    for (int i = 0; i < N; i++) begin
      if (u_if.ack[i]) begin
        pidx[i]++;
        if (pidx[i] >= plen[i]) begin
          u_if.req[i] = 1'b0; plen[i] = 0;
        end else begin
          present(i);
          if (pstall[i] > 0) begin
            u_if.req[i] = 1'b0; stall[i] = pstall[i];
          end
        end
      end else if (plen[i] != 0 && !u_if.req[i]) begin
        if (stall[i] > 0) stall[i]--;
        else u_if.req[i] = 1'b1;
      end else if (plen[i] == 0 && rand_en && $urandom_range(0, 99) < rand_pct) begin
        new_pkt(i, $urandom_range(1, rand_max_len), 8'($urandom), 8'($urandom), 8'($urandom),
                ($urandom_range(0, 99) < rand_stall_pct) ? $urandom_range(0, 1400) : 0);
      end
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    agent_step();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_until_log(input int k, input int budget);
    int b;
    b = budget;
    while (log_q.size() < k && b > 0) begin
      tick();
      b--;
    end
    chk("wait_loads", log_q.size(), k);
  endtask

  task automatic clear_agents();
    for (int i = 0; i < N; i++) begin
      plen[i] = 0; pidx[i] = 0; stall[i] = 0; pstall[i] = 0;
    end
    u_if.req = '0; u_if.last = '0; u_if.data = '0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int base, b;
    clear_agents();
    #1 sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("reset_grant", u_if.grant, 0);
    chk("reset_txdata", u_if.tx_data, 0);
    sys_rst = 1'b0;

    // Single byte
    new_pkt(0, 1, 8'hA5, 8'h00, 8'h00, 0);
    run_until_log(1, 10);
    if (log_q.size() >= 1) begin
      chk("single_idx", log_q[0].idx, 0);
      chk("single_byte", log_q[0].b, 8'hA5);
    end
    run(300);
    chk("single_released", u_if.grant, 0);

    // Packet lock: req2 waits behind a 3-byte packet from req0
    base = log_q.size();
    new_pkt(0, 3, 8'h11, 8'h22, 8'h33, 0);
    tick();
    new_pkt(2, 1, 8'h77, 8'h00, 8'h00, 0);
    run_until_log(base + 4, 1200);
    if (log_q.size() >= base + 4) begin
      chk("lock_b0", log_q[base].b, 8'h11);
      chk("lock_b1", log_q[base+1].b, 8'h22);
      chk("lock_b2", log_q[base+2].b, 8'h33);
      chk("lock_b3", log_q[base+3].b, 8'h77);
      chk("lock_idx3", log_q[base+3].idx, 2);
      for (int k = 1; k < 4; k++)
        chk("lock_spacing", log_q[base+k].cyc - log_q[base].cyc, 257 * k);
    end

    // Round robin with all requesters refilling 1-byte packets
    base = log_q.size();
    rand_en = 1; rand_pct = 100; rand_max_len = 1; rand_stall_pct = 0;
    run_until_log(base + 5, 1600);
    rand_en = 0;
    if (log_q.size() >= base + 5) begin
      chk("rr_first", log_q[base].idx, 3);
      for (int k = 1; k < 5; k++) begin
        chk("rr_order", log_q[base+k].idx, (log_q[base].idx + k) % N);
        chk("rr_spacing", log_q[base+k].cyc - log_q[base+k-1].cyc, 257);
      end
    end
    run(1300);

    // Timeout: req1 stalls mid-packet, req3 pending
    base = log_q.size();
    new_pkt(1, 2, 8'h40, 8'h41, 8'h00, 1500);
    run(5);
    new_pkt(3, 1, 8'h3C, 8'h00, 8'h00, 0);
    run_until_log(base + 3, 3500);
    if (log_q.size() >= base + 3) begin
      chk("to_first", log_q[base].b, 8'h40);
      chk("to_next_idx", log_q[base+1].idx, 3);
      chk("to_release_gap", log_q[base+1].cyc - log_q[base].cyc, FRAME_CYCLES + HOLD_TIMEOUT + 1);
      chk("to_resume_idx", log_q[base+2].idx, 1);
      chk("to_resume_byte", log_q[base+2].b, 8'h41);
    end
    run(300);

    // Reset while tx_send is high
    new_pkt(3, 2, 8'hC3, 8'hC4, 8'h00, 0);
    b = 20;
    while (!u_if.tx_send && b > 0) begin
      tick();
      b--;
    end
    chk("mid_send_seen", u_if.tx_send, 1);
    #5 sys_rst = 1'b1;
    #1;
    chk("arst_send", u_if.tx_send, 0);
    chk("arst_grant", u_if.grant, 0);
    chk("arst_busy", u_if.busy, 0);
    chk("arst_data", u_if.tx_data, 0);
    clear_agents();
    repeat (2) @(negedge sys_clk);
    base = log_q.size();
    new_pkt(3, 1, 8'h5A, 8'h00, 8'h00, 0);
    new_pkt(1, 1, 8'h1E, 8'h00, 8'h00, 0);
    sys_rst = 1'b0;
    run_until_log(base + 1, 10);
    if (log_q.size() >= base + 1) chk("post_rst_idx", log_q[base].idx, 1);
    run(600);

    // Randomized traffic with mid-packet stalls around the timeout
    rand_en = 1; rand_pct = 3; rand_max_len = 3; rand_stall_pct = 15;
    run(20000);
    rand_en = 0;
    run(200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one high-speed UART transmitter (the 2 Mbps, 25-clock-per-bit sender driven by a rising edge on its send input) between N requesters. It arbitrates whole packets, not bytes: once a requester wins, it keeps the transmitter until its byte flagged `last` has been sent or it goes silent for a timeout. The block generates the send edge and holds the data byte stable for the full frame. It paces frames itself, because the sender has no busy output.

## Interface
- `N`, 4: number of requesters (2..8).
- `SEND_HIGH`, 4: cycles `tx_send` is held high per byte (≥3; the sender double-syncs the edge).
- `FRAME_CYCLES`, 256: cycles from one `tx_send` rise to the earliest next rise (≥ SEND_HIGH+250; covers start, 8 data and full stop bit plus sync delay).
- `HOLD_TIMEOUT`, 1024: idle cycles allowed mid-packet before the owner is dropped (≥1).
- `sys_clk` in 1: single clock, 50 MHz.
- `sys_rst` in 1: asynchronous, active-high reset.
- `req` in N: requester i has a byte pending.
- `data` in 8*N: byte of requester i on bits [8i+7:8i].
- `last` in N: the pending byte of requester i ends its packet.
- `ack` out N: one-cycle one-hot pulse; requester i's byte was taken.
- `grant` out N: one-hot current owner; 0 when none.
- `busy` out 1: high whenever state ≠ IDLE.
- `tx_send` out 1: to the sender's send input; a rising edge starts a frame.
- `tx_data` out 8: to the sender's data input; stable from rise until next load.

## Operation
- Registers: state, owner index, rr pointer `ptr`, `last_seen`, frame counter (clog2(FRAME_CYCLES) bits), hold counter (clog2(HOLD_TIMEOUT+1) bits).
- States: IDLE, SEND, GAP, HOLD.
- IDLE: if any `req` is high, the winner is the first set bit scanning from `ptr` upward, wrapping modulo N. On that edge:
  - `grant` ← onehot(winner), `tx_data` ← data[winner], `last_seen` ← last[winner].
  - `ack` ← onehot(winner) for one cycle, `tx_send` ← 1, frame counter ← 0, state ← SEND.
- SEND: frame counter increments each cycle. When the counter reaches SEND_HIGH−1: `tx_send` ← 0, state ← GAP.
- GAP: counter continues. At FRAME_CYCLES−1:
  - if `last_seen`=1, release the owner;
  - else hold counter ← 0 and state ← HOLD.
- HOLD: only `req[owner]` is examined; other requesters are ignored.
  - If `req[owner]`=1: load exactly as in IDLE but without arbitration (same owner), state ← SEND.
  - Else the hold counter increments. At HOLD_TIMEOUT−1, release the owner.
- Release: `grant` ← 0, `ptr` ← (owner+1) mod N, state ← IDLE.
- `tx_data` is never changed except at a load. `tx_send` is low in GAP, HOLD and IDLE.
- A requester must, on the cycle after its `ack`, either present its next byte or drop `req`. Its inputs are not sampled again until HOLD (or IDLE for a new packet).

## Timing
- Reset values: `grant`=0, `ack`=0, `busy`=0, `tx_send`=0, `tx_data`=0x00, `ptr`=0, state IDLE. Reset mid-frame aborts immediately and drives `tx_send` low; any sender frame already started completes on its own.
- Latency: `req` sampled high in IDLE → `ack`, `grant`, `tx_send`=1 and `tx_data` all valid one cycle later.
- `tx_send` is high for exactly SEND_HIGH cycles per byte. Successive rises are ≥FRAME_CYCLES+1 cycles apart (a back-to-back packet gives FRAME_CYCLES+1).
- The owner is released on the cycle the GAP counter hits FRAME_CYCLES−1 (last byte). A new winner can load on the next cycle, so the inter-packet rise spacing is FRAME_CYCLES+1.
- Simultaneous requests: pure round robin from `ptr`. No requester waits more than N−1 packets.
- `req[owner]` rising on the same cycle the hold counter expires: the timeout wins and the owner is released.
- `last` is sampled only with the byte being loaded. A 1-byte packet is `req` with `last`=1.

## Test plan
- Single byte: after reset, req=0001, data0=0xA5, last0=1 → one cycle later ack=0001, tx_data=0xA5, tx_send high 4 cycles. `busy` stays high for 256 cycles, then grant=0. The serial sender output decodes to 0xA5.
- Packet lock: req0 sends 3 bytes (0x11, 0x22, 0x33 with last on 0x33) while req2 is held high. Required: tx_send rises at t, t+257, t+514; req2 is acked only at t+771; data order is 11, 22, 33, then req2's byte.
- Round robin: all four requesters issue 1-byte packets continuously. Grant order is 0, 1, 2, 3, 0, with rises every 257 cycles.
- Timeout: req1 sends 0x40 with last=0, then drops req. The owner is released 1024 cycles after HOLD entry, ptr=2. A pending req3 is then granted before req1.
- Reset mid-SEND: assert sys_rst while tx_send=1 → tx_send, grant, busy and tx_data go to 0 asynchronously. After release, the first grant goes to the lowest-index requester.
- Edge spacing check: a monitor on tx_send confirms every high pulse is 4 cycles and every low interval is ≥252 cycles throughout all of the above scenarios.
